// File: rtl/i2c_eeprom_sequencer.sv
// Two-requester sequencer in front of an I2C master: arbitrates 32-bit EEPROM
// reads/writes, drives the controller handshake and waits out the write cycle.
module i2c_eeprom_sequencer #(
  parameter logic [6:0]  DEV_ADDR     = 7'h50,
  parameter logic [2:0]  CLK_RATE     = 3'd7,
  parameter int unsigned WR_CYCLE_CNT = 500000,
  parameter int unsigned TIMEOUT_CNT  = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_0,
  input  logic        i_wr_0,
  input  logic [15:0] i_addr_0,
  input  logic [31:0] i_wdata_0,
  output logic        o_done_0,
  output logic        o_err_0,
  input  logic        i_req_1,
  input  logic        i_wr_1,
  input  logic [15:0] i_addr_1,
  input  logic [31:0] i_wdata_1,
  output logic        o_done_1,
  output logic        o_err_1,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic [31:0] o_ctrl,
  output logic [6:0]  o_dev_addr,
  output logic [15:0] o_reg_addr,
  output logic [31:0] o_w_data,
  input  logic [31:0] i_status,
  input  logic [7:0]  i_rd_data,
  input  logic [7:0]  i_rd_data_2,
  input  logic [7:0]  i_rd_data_3,
  input  logic [7:0]  i_rd_data_4,
  output logic [2:0]  o_state
);

  localparam int WR_W = $clog2(WR_CYCLE_CNT + 1);
  localparam int TO_W = $clog2(TIMEOUT_CNT + 1);
  localparam logic [WR_W-1:0] WR_LAST = WR_W'(WR_CYCLE_CNT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RELEASE   = 3'd3,
    S_WR_WAIT   = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic            rd_q, rd_d;
  logic [15:0]     reg_addr_q, reg_addr_d;
  logic [31:0]     w_data_q, w_data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            fin_prev_q, fin_prev_d;
  logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [WR_W-1:0] wr_cnt_q, wr_cnt_d;

  logic fin_rise;
  logic ctl_active;
  logic ctl_idle;
  logic pick;
  logic status_unused;

  assign fin_rise      = i_status[1] & ~fin_prev_q;
  assign ctl_active    = i_status[10] | (|i_status[9:2]);
  assign ctl_idle      = (i_status[9:2] == 8'd0) & ~i_status[1];
  assign status_unused = ^{i_status[31:11], i_status[0]};

  // On a tie the requester that was not served last wins.
  assign pick = (i_req_0 & i_req_1) ? ~last_q : i_req_1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    rd_d       = rd_q;
    reg_addr_d = reg_addr_q;
    w_data_d   = w_data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    fin_prev_d = i_status[1];
    tmo_cnt_d  = tmo_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_0 | i_req_1) begin
          gnt_d      = pick;
          rd_d       = pick ? ~i_wr_1 : ~i_wr_0;
          reg_addr_d = pick ? i_addr_1 : i_addr_0;
          w_data_d   = pick ? i_wdata_1 : i_wdata_0;
          err_d      = 1'b0;
          tmo_cnt_d  = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tmo_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (ctl_active) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A finish that stays high is only honoured on its rising edge.
        if (fin_rise) begin
          if (rd_q) rdata_d = {i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4};
          state_d = S_RELEASE;
        end else if (tmo_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (ctl_idle) begin
          wr_cnt_d = '0;
          state_d  = (!rd_q && !err_q) ? S_WR_WAIT : S_RESP;
        end
      end
      S_WR_WAIT: begin
        if (wr_cnt_q == WR_LAST) state_d = S_RESP;
        else wr_cnt_d = wr_cnt_q + 1'b1;
      end
      S_RESP: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      rd_q       <= 1'b0;
      reg_addr_q <= '0;
      w_data_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      fin_prev_q <= 1'b0;
      tmo_cnt_q  <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      rd_q       <= rd_d;
      reg_addr_q <= reg_addr_d;
      w_data_q   <= w_data_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      fin_prev_q <= fin_prev_d;
      tmo_cnt_q  <= tmo_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  logic ctl_en;
  assign ctl_en     = (state_q == S_ISSUE) | (state_q == S_WAIT_DONE);
  assign o_ctrl     = {25'd0, CLK_RATE, 2'b00, rd_q, ctl_en};
  assign o_busy     = (state_q != S_IDLE);
  assign o_done_0   = (state_q == S_RESP) & ~gnt_q;
  assign o_done_1   = (state_q == S_RESP) & gnt_q;
  assign o_err_0    = o_done_0 & err_q;
  assign o_err_1    = o_done_1 & err_q;
  assign o_rdata    = rdata_q;
  assign o_dev_addr = DEV_ADDR;
  assign o_reg_addr = reg_addr_q;
  assign o_w_data   = w_data_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_i2c_eeprom_sequencer.sv
// Bench for i2c_eeprom_sequencer: transaction-level model of arbitration,
// completion latency and read data, plus a scripted controller model.
module tb_i2c_eeprom_sequencer;
  localparam int WR_CYC = 20;
  localparam int TO_CYC = 50;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_0 = 0, i_wr_0 = 0, i_req_1 = 0, i_wr_1 = 0;
  logic [15:0] i_addr_0 = 0, i_addr_1 = 0;
  logic [31:0] i_wdata_0 = 0, i_wdata_1 = 0;
  logic        o_done_0, o_err_0, o_done_1, o_err_1, o_busy;
  logic [31:0] o_rdata, o_ctrl, o_w_data;
  logic [6:0]  o_dev_addr;
  logic [15:0] o_reg_addr;
  logic [31:0] i_status = 0;
  logic [7:0]  i_rd_data = 0, i_rd_data_2 = 0, i_rd_data_3 = 0, i_rd_data_4 = 0;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  i2c_eeprom_sequencer #(.DEV_ADDR(7'h50), .CLK_RATE(3'd7),
    .WR_CYCLE_CNT(WR_CYC), .TIMEOUT_CNT(TO_CYC)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_0(i_req_0), .i_wr_0(i_wr_0), .i_addr_0(i_addr_0), .i_wdata_0(i_wdata_0),
    .o_done_0(o_done_0), .o_err_0(o_err_0),
    .i_req_1(i_req_1), .i_wr_1(i_wr_1), .i_addr_1(i_addr_1), .i_wdata_1(i_wdata_1),
    .o_done_1(o_done_1), .o_err_1(o_err_1),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_ctrl(o_ctrl), .o_dev_addr(o_dev_addr),
    .o_reg_addr(o_reg_addr), .o_w_data(o_w_data), .i_status(i_status),
    .i_rd_data(i_rd_data), .i_rd_data_2(i_rd_data_2), .i_rd_data_3(i_rd_data_3),
    .i_rd_data_4(i_rd_data_4), .o_state(o_state));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-requester expectations, written only by the driver.
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];
  logic        exp_lat [2];

  // Controller model knobs.
  logic        ctl_never_fin = 0;
  int          ctl_hold = 0;
  logic [31:0] ctl_bytes = 0;
  int          cyc_en = 0;
  logic        fin_up = 0;
  int          hold_left = 0;

  always @(negedge clk) begin
    if (i_rst) begin
      cyc_en = 0; fin_up = 0; hold_left = 0; i_status = 0;
    end else if (!o_ctrl[0]) begin
      cyc_en = 0;
      if (fin_up && hold_left > 0) begin
        hold_left--;
        {i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4} = 32'hEEEE_EEEE;
      end else begin
        i_status = 0;
        fin_up = 0;
      end
    end else begin
      cyc_en++;
      if (cyc_en >= 2) begin
        i_status[10]  = 1'b1;
        i_status[9:2] = 8'h05;
      end
      if (!ctl_never_fin && cyc_en == 6) begin
        i_status[1] = 1'b1;
        {i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4} = ctl_bytes;
        fin_up = 1;
        hold_left = ctl_hold;
      end else if (fin_up) begin
        {i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4} = 32'hEEEE_EEEE;
      end
    end
  end

  // Transaction-level model and per-cycle compare.
  logic        cur_v = 0, cur_id = 0, cur_rd = 0, cur_err = 0, cur_lat = 0;
  logic [15:0] cur_addr = 0;
  logic [31:0] cur_wd = 0, cur_erd = 0;
  logic        last_gnt = 1;
  logic [31:0] mdl_rdata = 0;
  logic        busy_prev = 0, en_prev = 0;
  int          en_cnt = 0, fall_cyc = 0, cyc = 0, exp_lat_cyc = 0;
  int          grant_log[$];
  logic        err_log[$];

  always @(negedge clk) begin
    cyc++;
    check("ctrl_fixed_bits", o_ctrl & 32'hFFFF_FFF0, 32'h0000_0070);
    check("dev_addr", 32'(o_dev_addr), 32'h0000_0050);
    if (i_rst) begin
      cur_v = 0; last_gnt = 1; mdl_rdata = 0; en_cnt = 0;
    end else begin
      if (o_busy && !busy_prev) begin
        n_chk++;
        if (!i_req_0 && !i_req_1) begin
          n_err++;
          $display("FAIL grant_without_request: got busy=1 expected busy=0");
        end else begin
          cur_id   = (i_req_0 && i_req_1) ? ~last_gnt : i_req_1;
          cur_rd   = cur_id ? !i_wr_1 : !i_wr_0;
          cur_addr = cur_id ? i_addr_1 : i_addr_0;
          cur_wd   = cur_id ? i_wdata_1 : i_wdata_0;
          cur_err  = exp_err[cur_id];
          cur_erd  = exp_rd[cur_id];
          cur_lat  = exp_lat[cur_id];
          cur_v    = 1;
          en_cnt   = 0;
        end
      end
      if (cur_v && o_busy) begin
        check("op_mode", 32'(o_ctrl[3:1]), 32'(cur_rd));
        check("reg_addr", 32'(o_reg_addr), 32'(cur_addr));
        check("w_data", o_w_data, cur_wd);
      end
      if (o_ctrl[0]) en_cnt++;
      if (!o_ctrl[0] && en_prev) begin
        fall_cyc = cyc;
        if (cur_v && cur_err) check("timeout_len", en_cnt, TO_CYC);
      end
      if ((o_err_0 && !o_done_0) || (o_err_1 && !o_done_1)) begin
        n_chk++; n_err++;
        $display("FAIL err_without_done: got err=1 expected err=0");
      end
      if (o_done_0 || o_done_1) begin
        n_chk++;
        if (!cur_v) begin
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          check("done_one_hot", 32'(o_done_0 & o_done_1), 32'd0);
          check("done_id", 32'(o_done_1), 32'(cur_id));
          check("done_err", 32'(o_done_1 ? o_err_1 : o_err_0), 32'(cur_err));
          if (cur_rd && !cur_err) mdl_rdata = cur_erd;
          check("rdata", o_rdata, mdl_rdata);
          if (cur_lat) begin
            exp_lat_cyc = (!cur_rd && !cur_err) ? WR_CYC + 1 : 1;
            check("done_latency", cyc - fall_cyc, exp_lat_cyc);
          end
          grant_log.push_back(32'(cur_id));
          err_log.push_back(o_done_1 ? o_err_1 : o_err_0);
          last_gnt = cur_id;
          cur_v = 0;
        end
      end
    end
    busy_prev = o_busy;
    en_prev = o_ctrl[0];
  end

  task automatic issue(input int id, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rd, input logic lat);
    exp_err[id] = e_err;
    exp_rd[id]  = e_rd;
    exp_lat[id] = lat;
    if (id == 0) begin
      i_wr_0 = wr; i_addr_0 = addr; i_wdata_0 = wd; i_req_0 = 1;
    end else begin
      i_wr_1 = wr; i_addr_1 = addr; i_wdata_1 = wd; i_req_1 = 1;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (o_done_0) i_req_0 = 0;
      if (o_done_1) i_req_1 = 0;
      if (!i_req_0 && !i_req_1 && !o_busy) break;
    end
    n_chk++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL run_budget: got %0d cycles expected completion within %0d", k, budget);
      i_req_0 = 0; i_req_1 = 0;
    end
  endtask

  task automatic pulse_reset();
    i_rst = 1;
    repeat (2) @(posedge clk);
    #1 i_rst = 0;
  endtask

  int n_before;
  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", o_ctrl, 32'h0000_0070);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_reg_addr", 32'(o_reg_addr), 32'd0);
    check("rst_w_data", o_w_data, 32'd0);
    check("rst_done", 32'({o_done_0, o_done_1, o_err_0, o_err_1}), 32'd0);
    i_rst = 0;

    // Single write from requester 0.
    issue(0, 1'b1, 16'h0010, 32'hA5A5_5A5A, 1'b0, 32'd0, 1'b1);
    run_until_idle(400);
    check("wr_reg_addr", 32'(o_reg_addr), 32'h0000_0010);
    check("wr_w_data", o_w_data, 32'hA5A5_5A5A);
    check("wr_err", 32'(err_log.size() > 0 ? err_log[$] : 1'b1), 32'd0);

    // Single read from requester 1.
    ctl_bytes = 32'h1234_5678;
    issue(1, 1'b0, 16'h0100, 32'd0, 1'b0, 32'h1234_5678, 1'b1);
    run_until_idle(400);
    check("rd_rdata", o_rdata, 32'h1234_5678);

    // Two rounds of simultaneous requests after a fresh reset.
    pulse_reset();
    grant_log.delete();
    ctl_bytes = 32'hCAFE_F00D;
    for (int r = 0; r < 2; r++) begin
      issue(0, 1'b1, 16'h0200 + 16'(r), 32'h1122_3344 + 32'(r), 1'b0, 32'd0, 1'b1);
      issue(1, 1'b0, 16'h0300 + 16'(r), 32'd0, 1'b0, 32'hCAFE_F00D, 1'b1);
      run_until_idle(1000);
    end
    check("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_order_%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);

    // Controller never finishes: timeout, then a normal read.
    ctl_never_fin = 1;
    issue(0, 1'b0, 16'h0400, 32'd0, 1'b1, 32'd0, 1'b1);
    run_until_idle(400);
    check("tmo_err", 32'(err_log.size() > 0 ? err_log[$] : 1'b0), 32'd1);
    check("tmo_rdata_kept", o_rdata, 32'hCAFE_F00D);
    check("tmo_en_low", 32'(o_ctrl[0]), 32'd0);
    ctl_never_fin = 0;
    ctl_bytes = 32'h0BAD_BEEF;
    issue(1, 1'b0, 16'h0500, 32'd0, 1'b0, 32'h0BAD_BEEF, 1'b1);
    run_until_idle(400);
    check("post_tmo_rdata", o_rdata, 32'h0BAD_BEEF);
    check("post_tmo_err", 32'(err_log.size() > 0 ? err_log[$] : 1'b1), 32'd0);

    // Finish held high for several cycles.
    ctl_hold = 4;
    ctl_bytes = 32'h9ABC_DEF0;
    n_before = grant_log.size();
    issue(0, 1'b0, 16'h0600, 32'd0, 1'b0, 32'h9ABC_DEF0, 1'b0);
    run_until_idle(400);
    check("hold_rdata", o_rdata, 32'h9ABC_DEF0);
    check("hold_one_done", grant_log.size() - n_before, 1);
    ctl_hold = 0;

    // Reset while waiting on the controller.
    ctl_never_fin = 1;
    issue(1, 1'b0, 16'h0700, 32'd0, 1'b0, 32'd0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_en_before", 32'(o_ctrl[0]), 32'd1);
    i_rst = 1;
    i_req_1 = 0;
    n_before = grant_log.size();
    @(posedge clk); #1;
    check("abort_en_dropped", 32'(o_ctrl[0]), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    i_rst = 0;
    ctl_never_fin = 0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", grant_log.size() - n_before, 0);

    // Service resumes after the abort.
    issue(1, 1'b1, 16'h0800, 32'hDEAD_0001, 1'b0, 32'd0, 1'b1);
    run_until_idle(400);
    check("resume_w_data", o_w_data, 32'hDEAD_0001);
    check("resume_done", grant_log.size() - n_before, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
